// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: operator codes, FSM
// encodings, bus direction codes, the bus command payload and small
// decode helpers used by both the top and the load aligner.
package mem_access_unit_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned OP_W   = 8;
   localparam int unsigned LANES  = 4;
   localparam int unsigned CNT_W  = 8;

   // Active level of the synchronous reset input
   localparam logic RESET_ENABLE = 1'b0;

   // Memory operator codes presented by the EX/MEM register
   localparam logic [OP_W-1:0] OP_LB  = 8'hE0;
   localparam logic [OP_W-1:0] OP_LH  = 8'hE1;
   localparam logic [OP_W-1:0] OP_LW  = 8'hE3;
   localparam logic [OP_W-1:0] OP_LBU = 8'hE4;
   localparam logic [OP_W-1:0] OP_LHU = 8'hE5;
   localparam logic [OP_W-1:0] OP_SB  = 8'hE8;
   localparam logic [OP_W-1:0] OP_SH  = 8'hE9;
   localparam logic [OP_W-1:0] OP_SW  = 8'hEB;

   localparam logic BUS_READ  = 1'b0;
   localparam logic BUS_WRITE = 1'b1;

   typedef enum logic [1:0] {
      MAU_IDLE = 2'd0,
      MAU_WAIT = 2'd1,
      MAU_DONE = 2'd2
   } mau_state_e;

   // Registered data-memory bus command
   typedef struct packed {
      logic             we;
      logic [XLEN-1:0]  addr;
      logic [LANES-1:0] byte_sel;
      logic [XLEN-1:0]  wdata;
   } bus_cmd_t;

   function automatic logic is_load(input logic [OP_W-1:0] op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
             (op == OP_LHU) || (op == OP_LW);
   endfunction

   function automatic logic is_store(input logic [OP_W-1:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_mem_op(input logic [OP_W-1:0] op);
      return is_load(op) || is_store(op);
   endfunction

   // Halfwords need addr[0]=0, words need addr[1:0]=0, bytes always fit
   function automatic logic is_aligned(input logic [OP_W-1:0] op,
                                       input logic [1:0]      lo);
      logic ok;
      case (op)
         OP_LH, OP_LHU, OP_SH: ok = ~lo[0];
         OP_LW, OP_SW:         ok = (lo == 2'b00);
         default:              ok = 1'b1;
      endcase
      return ok;
   endfunction

   // Big-endian lanes: byte offset 0 lives in lane 3 (bits 31:24)
   function automatic logic [LANES-1:0] lane_sel(input logic [OP_W-1:0] op,
                                                  input logic [1:0]      lo);
      logic [LANES-1:0] sel;
      case (op)
         OP_LB, OP_LBU, OP_SB: sel = 4'b1000 >> lo;
         OP_LH, OP_LHU, OP_SH: sel = lo[1] ? 4'b0011 : 4'b1100;
         default:              sel = 4'b1111;
      endcase
      return sel;
   endfunction

   // Replicate store data across lanes so the selected lanes carry it
   function automatic logic [XLEN-1:0] store_data(input logic [OP_W-1:0] op,
                                                  input logic [XLEN-1:0] b);
      logic [XLEN-1:0] d;
      case (op)
         OP_SB:   d = {4{b[7:0]}};
         OP_SH:   d = {2{b[15:0]}};
         default: d = b;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load extraction: picks the addressed byte/halfword out of a big-endian
// read word and sign- or zero-extends it to 32 bits.
//   operator    : load operator (LW or non-load passes the word through)
//   addr_lo     : byte offset within the word
//   rdata       : word returned by the bus
//   load_data_c : extended result (combinational)
module mem_load_align
   import mem_access_unit_pkg::*;
(
   input  logic [OP_W-1:0] operator,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] load_data_c
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Lane extraction, offset 0 is the most significant byte
   always_comb begin : extract
      byte_v = rdata[31:24];
      case (addr_lo)
         2'd0:    byte_v = rdata[31:24];
         2'd1:    byte_v = rdata[23:16];
         2'd2:    byte_v = rdata[15:8];
         default: byte_v = rdata[7:0];
      endcase
      half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];
   end

   // Extension by operator
   always_comb begin : extend
      load_data_c = rdata;
      case (operator)
         OP_LB:   load_data_c = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  load_data_c = {24'h000000, byte_v};
         OP_LH:   load_data_c = {{16{half_v[15]}}, half_v};
         OP_LHU:  load_data_c = {16'h0000, half_v};
         default: load_data_c = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit.
// Issues loads/stores from the EX/MEM register over a req/ack bus, steers
// store lanes, extends load data, stalls the pipeline while an access is
// outstanding and hands the writeback triple to MEM/WB.
//   clock, reset           : clock, synchronous active-low reset
//   mem_*                  : EX/MEM register outputs
//   bus_*                  : data-memory bus (registered request side)
//   mem_stall_request      : stall to pipeline control (combinational)
//   wb_reg_write_*         : writeback triple to MEM/WB (combinational)
//   misaligned, bus_error  : one-cycle status pulses (registered)
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic              clock,
   input  logic              reset,
   input  logic [OP_W-1:0]   mem_operator,
   input  logic [XLEN-1:0]   mem_operand_a,
   input  logic [XLEN-1:0]   mem_operand_b,
   input  logic              mem_reg_write_enable,
   input  logic [REG_AW-1:0] mem_reg_write_address,
   input  logic [XLEN-1:0]   mem_reg_write_data,
   output logic              bus_req,
   output logic              bus_we,
   output logic [XLEN-1:0]   bus_addr,
   output logic [LANES-1:0]  bus_byte_sel,
   output logic [XLEN-1:0]   bus_wdata,
   input  logic              bus_ack,
   input  logic [XLEN-1:0]   bus_rdata,
   output logic              mem_stall_request,
   output logic              wb_reg_write_enable,
   output logic [REG_AW-1:0] wb_reg_write_address,
   output logic [XLEN-1:0]   wb_reg_write_data,
   output logic              misaligned,
   output logic              bus_error
);

   localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   mau_state_e       state_q, state_d;
   logic             bus_req_q, bus_req_d;
   bus_cmd_t         bus_cmd_q, bus_cmd_d;
   logic             misaligned_q, misaligned_d;
   logic             bus_error_q, bus_error_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [XLEN-1:0]  load_buf_q, load_buf_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [1:0]       addr_lo_q, addr_lo_d;

   logic             mem_op_c;
   logic             aligned_c;
   logic [XLEN-1:0]  load_ext_c;

   assign mem_op_c  = is_mem_op(mem_operator);
   assign aligned_c = is_aligned(mem_operator, mem_operand_a[1:0]);

   // Extraction uses the operator/offset latched at issue time
   mem_load_align u_load_align (
      .operator    (op_q),
      .addr_lo     (addr_lo_q),
      .rdata       (bus_rdata),
      .load_data_c (load_ext_c)
   );

   // State and registered outputs
   always_ff @(posedge clock) begin : regs
      if (reset == RESET_ENABLE) begin
         state_q      <= MAU_IDLE;
         bus_req_q    <= 1'b0;
         bus_cmd_q    <= '0;
         misaligned_q <= 1'b0;
         bus_error_q  <= 1'b0;
         cnt_q        <= '0;
         load_buf_q   <= '0;
         op_q         <= '0;
         addr_lo_q    <= '0;
      end else begin
         state_q      <= state_d;
         bus_req_q    <= bus_req_d;
         bus_cmd_q    <= bus_cmd_d;
         misaligned_q <= misaligned_d;
         bus_error_q  <= bus_error_d;
         cnt_q        <= cnt_d;
         load_buf_q   <= load_buf_d;
         op_q         <= op_d;
         addr_lo_q    <= addr_lo_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin : fsm_next
      state_d      = state_q;
      bus_req_d    = bus_req_q;
      bus_cmd_d    = bus_cmd_q;
      misaligned_d = 1'b0;
      bus_error_d  = 1'b0;
      cnt_d        = cnt_q;
      load_buf_d   = load_buf_q;
      op_d         = op_q;
      addr_lo_d    = addr_lo_q;
      cnt_inc      = cnt_q + CNT_W'(1);

      case (state_q)
         MAU_IDLE: begin
            if (mem_op_c) begin
               if (aligned_c) begin
                  bus_req_d          = 1'b1;
                  bus_cmd_d.we       = is_store(mem_operator) ? BUS_WRITE : BUS_READ;
                  bus_cmd_d.addr     = {mem_operand_a[XLEN-1:2], 2'b00};
                  bus_cmd_d.byte_sel = lane_sel(mem_operator, mem_operand_a[1:0]);
                  bus_cmd_d.wdata    = store_data(mem_operator, mem_operand_b);
                  cnt_d              = '0;
                  op_d               = mem_operator;
                  addr_lo_d          = mem_operand_a[1:0];
                  state_d            = MAU_WAIT;
               end else begin
                  // Suppress the access entirely and retire the op via DONE
                  misaligned_d = 1'b1;
                  state_d      = MAU_DONE;
               end
            end
         end

         MAU_WAIT: begin
            // Ack is checked first so a same-cycle timeout loses
            if (bus_ack) begin
               bus_req_d = 1'b0;
               if (is_load(op_q)) begin
                  load_buf_d = load_ext_c;
               end
               state_d = MAU_DONE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TIMEOUT_LIMIT) begin
                  bus_req_d   = 1'b0;
                  bus_error_d = 1'b1;
                  state_d     = MAU_DONE;
               end
            end
         end

         MAU_DONE: begin
            // EX/MEM still shows the op here; never reissue it
            state_d = MAU_IDLE;
         end

         default: begin
            state_d   = MAU_IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   // Stall and writeback hand-off
   always_comb begin : wb_out
      mem_stall_request    = 1'b0;
      wb_reg_write_enable  = mem_reg_write_enable;
      wb_reg_write_address = mem_reg_write_address;
      wb_reg_write_data    = mem_reg_write_data;

      case (state_q)
         MAU_IDLE: mem_stall_request = mem_op_c;
         MAU_WAIT: mem_stall_request = 1'b1;
         default:  mem_stall_request = 1'b0;
      endcase

      if (mem_op_c) begin
         wb_reg_write_enable = 1'b0;
         // misaligned_q/bus_error_q are high exactly in the DONE cycle of an abandoned op
         if (is_load(mem_operator) && (state_q == MAU_DONE) &&
             !misaligned_q && !bus_error_q) begin
            wb_reg_write_enable = mem_reg_write_enable;
            wb_reg_write_data   = load_buf_q;
         end
      end

      if (mem_stall_request) begin
         wb_reg_write_enable = 1'b0;
      end
   end

   assign bus_req      = bus_req_q;
   assign bus_we       = bus_cmd_q.we;
   assign bus_addr     = bus_cmd_q.addr;
   assign bus_byte_sel = bus_cmd_q.byte_sel;
   assign bus_wdata    = bus_cmd_q.wdata;
   assign misaligned   = misaligned_q;
   assign bus_error    = bus_error_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs (mem_* signals). It drives the data-memory bus through a req/ack handshake.
- Performs byte-lane steering for stores, and extraction plus sign/zero extension for loads.
- Raises a stall request to the pipeline control unit while an access is outstanding.
- Hands the register-writeback triple to the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before abandoning the access and flagging bus_error (8-bit counter; must be 1..255)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset (`RESET_ENABLE == 1'b0)
mem_operator  in  8  operator from EX/MEM register (`OP_LB/LBU/LH/LHU/LW/SB/SH/SW; any other value = non-memory)
mem_operand_a  in  32  effective address
mem_operand_b  in  32  store data (rt value)
mem_reg_write_enable  in  1  writeback enable from EX/MEM
mem_reg_write_address  in  5  writeback register
mem_reg_write_data  in  32  ALU result for non-memory ops
bus_req  out  1  access request
bus_we  out  1  1 = store
bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
bus_byte_sel  out  4  byte-lane enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  one-cycle completion pulse; bus_rdata valid with it
bus_rdata  in  32  read word
mem_stall_request  out  1  to control; stalls stages 0..3 while high
wb_reg_write_enable  out  1  to MEM/WB register
wb_reg_write_address  out  5  to MEM/WB register
wb_reg_write_data  out  32  to MEM/WB register
misaligned  out  1  one-cycle pulse: misaligned access suppressed
bus_error  out  1  one-cycle pulse: timeout

Behaviour:
- Clocking: all state changes on posedge clock. Reset sampled synchronously, active-low.
- Reset values: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_byte_sel=0, bus_wdata=0, misaligned=0, bus_error=0, timeout counter=0, load buffer=0. Combinational outputs follow from these values.
- FSM states:
  - IDLE: memory op present and aligned → register bus_* fields, bus_req=1, go to WAIT.
  - WAIT: bus_ack → capture extended load data, bus_req=0, go to DONE. Counter reaches TIMEOUT_CYCLES → bus_req=0, bus_error pulse, go to DONE.
  - DONE: unconditionally go to IDLE next cycle. Never reissues the access even though EX/MEM still presents the same op in this cycle.
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - Misaligned op: no request issued, misaligned pulses for one cycle, state → DONE. wb_reg_write_enable forced 0 for that op.
- mem_stall_request (combinational):
  - High in IDLE when a memory op is present.
  - High throughout WAIT.
  - Low in DONE and for non-memory ops.
  - Net stall is therefore access latency + 1 cycles (minimum 2 with ack in the first WAIT cycle).
- Store lanes (big-endian, MIPS): addr[1:0]=0 selects byte 3.
  - SB: sel=4'b1000>>addr[1:0], wdata={4{b[7:0]}}.
  - SH: sel=addr[1]?0011:1100, wdata={2{b[15:0]}}.
  - SW: sel=1111, wdata=b.
- Loads: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Writeback outputs (combinational):
  - Non-memory op: pass-through of mem_reg_write_*.
  - Load in DONE: enable=mem_reg_write_enable, data=load buffer.
  - Store, or any cycle with stall_request=1: enable=0.
  - Load aborted by timeout: enable=0.
- Timeout counter: cleared on entry to WAIT, increments each WAIT cycle without ack.
- Simultaneous ack and timeout in the same cycle: ack wins; no error.
- Reset mid-WAIT: bus_req drops on that edge. A late ack arriving in IDLE is ignored.

Decomposition:
- defines.v (shared) gains the following; the block uses only these names:
  - operator codes `OP_LB .. `OP_SW
  - FSM encodings `MAU_IDLE/`MAU_WAIT/`MAU_DONE
  - `BUS_READ/`BUS_WRITE
- One combinational sub-module, mem_load_align: (operator, addr[1:0], rdata) → extended 32-bit value.

Test Plan:
- LW addr 0x100, ack after 3 WAIT cycles, rdata 0xDEADBEEF → bus_addr 0x100, sel 1111; stall high 4 cycles; wb_data 0xDEADBEEF, enable 1 in DONE.
- LB addr 0x103, rdata 0x000000F0 → sel 0001; wb_data 0xFFFFFFF0. LBU same access → 0x000000F0.
- SH addr 0x202, b=0x00001234 → bus_we 1, sel 0011, wdata 0x12341234; wb enable 0.
- LW addr 0x101 → no bus_req, misaligned pulses 1 cycle, 1-cycle stall, wb enable 0.
- TIMEOUT_CYCLES=4, no ack → bus_req high exactly 4 WAIT cycles, bus_error pulse, wb enable 0; next op proceeds normally.
- reset=0 asserted during WAIT, then ack next cycle → bus_req 0, state IDLE, no wb write, no stall.
